// File: rtl/ucsbece154_icache_pkg.sv
// rtl/ucsbece154_icache_pkg.sv - shared types and constants for the icache refill path
//
// Holds the refill FSM state encoding, the line-offset width helper and the
// burst-order encodings that the cache, the memory model and the refill
// engine must agree on.
package ucsbece154_icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RECV = 2'd2,
        ST_DONE = 2'd3
    } refill_state_t;

    // Burst order: ascending offsets, or critical word first then ascending
    // with the critical offset skipped.
    localparam int CWF_ASCENDING  = 0;
    localparam int CWF_CRIT_FIRST = 1;

    function automatic int offset_w(input int block_words);
        return $clog2(block_words);
    endfunction

endpackage

// File: rtl/ucsbece154_refill_order.sv
// rtl/ucsbece154_refill_order.sv - maps a burst beat index to its word offset in the line
//
// Ports:
//   beat   in   index of the beat within the burst (0..BLOCK_WORDS-1)
//   crit   in   offset of the missed (critical) word
//   offset out  word offset in the line that this beat carries
module ucsbece154_refill_order
    import ucsbece154_icache_pkg::*;
#(
    parameter int  BLOCK_WORDS = 4,
    parameter int  CWF         = CWF_ASCENDING,
    localparam int OFFSET_W    = offset_w(BLOCK_WORDS)
) (
    input  logic [OFFSET_W-1:0] beat,
    input  logic [OFFSET_W-1:0] crit,
    output logic [OFFSET_W-1:0] offset
);

    logic [OFFSET_W-1:0] prev;

    always_comb begin
        prev   = beat - 1'b1;
        offset = beat;
        if (CWF == CWF_CRIT_FIRST) begin
            // Beat 0 is the critical word; later beats walk the remaining
            // offsets upward, stepping over the one already delivered.
            if (beat == '0) begin
                offset = crit;
            end else if (prev < crit) begin
                offset = prev;
            end else begin
                offset = beat;
            end
        end
    end

endmodule

// File: rtl/ucsbece154_icache_refill.sv
// rtl/ucsbece154_icache_refill.sv - instruction cache line refill engine
//
// Accepts one block miss, issues a single memory read request, writes the
// returned burst into the data array and forwards the critical word early.
// Aborts with timeout_err if memory stays silent for TIMEOUT_CYCLES cycles.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   miss_valid/miss_addr/miss_ready  miss handshake from the tag logic
//   MemReadRequest/MemReadAddress  one-cycle read request to memory
//   MemDataIn/MemDataReady         burst data from memory
//   fill_we/fill_offset/fill_data/fill_addr  data-array write port
//   fill_done                      pulse: line complete, may be marked valid
//   crit_valid/crit_data           pulse: critical word for the fetch stage
//   timeout_err                    pulse: refill aborted, line stays invalid
module ucsbece154_icache_refill
    import ucsbece154_icache_pkg::*;
#(
    parameter int  BLOCK_WORDS    = 4,
    parameter int  CWF            = CWF_ASCENDING,
    parameter int  TIMEOUT_CYCLES = 255,
    localparam int OFFSET_W       = offset_w(BLOCK_WORDS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                miss_valid,
    input  logic [31:0]         miss_addr,
    output logic                miss_ready,
    output logic                MemReadRequest,
    output logic [31:0]         MemReadAddress,
    input  logic [31:0]         MemDataIn,
    input  logic                MemDataReady,
    output logic                fill_we,
    output logic [OFFSET_W-1:0] fill_offset,
    output logic [31:0]         fill_data,
    output logic [31:0]         fill_addr,
    output logic                fill_done,
    output logic                crit_valid,
    output logic [31:0]         crit_data,
    output logic                timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0]    IDLE_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);

    refill_state_t       state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [OFFSET_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]    idle_q, idle_d;
    logic                mem_req_q, mem_req_d;
    logic                fill_we_q, fill_we_d;
    logic [OFFSET_W-1:0] fill_offset_q, fill_offset_d;
    logic [31:0]         fill_data_q, fill_data_d;
    logic                crit_valid_q, crit_valid_d;
    logic [31:0]         crit_data_q, crit_data_d;
    logic                fill_done_q, fill_done_d;
    logic                timeout_err_q, timeout_err_d;

    logic [OFFSET_W-1:0] crit;
    logic [OFFSET_W-1:0] beat_offset;

    assign crit = addr_q[2 +: OFFSET_W];

    ucsbece154_refill_order #(
        .BLOCK_WORDS (BLOCK_WORDS),
        .CWF         (CWF)
    ) u_order (
        .beat   (beat_q),
        .crit   (crit),
        .offset (beat_offset)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        beat_d        = beat_q;
        idle_d        = idle_q;
        mem_req_d     = 1'b0;
        fill_we_d     = 1'b0;
        fill_offset_d = fill_offset_q;
        fill_data_d   = fill_data_q;
        crit_valid_d  = 1'b0;
        crit_data_d   = crit_data_q;
        fill_done_d   = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (miss_valid) begin
                    addr_d    = miss_addr;
                    beat_d    = '0;
                    idle_d    = '0;
                    // Registered so the request is high exactly during REQ.
                    mem_req_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                idle_d  = '0;
                state_d = ST_RECV;
            end
            ST_RECV: begin
                if (MemDataReady) begin
                    fill_we_d     = 1'b1;
                    fill_offset_d = beat_offset;
                    fill_data_d   = MemDataIn;
                    if (beat_offset == crit) begin
                        crit_valid_d = 1'b1;
                        crit_data_d  = MemDataIn;
                    end
                    idle_d = '0;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end else if (idle_q == IDLE_MAX) begin
                    // This is the TIMEOUT_CYCLES-th silent cycle in a row.
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            ST_DONE: begin
                fill_done_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            beat_q        <= '0;
            idle_q        <= '0;
            mem_req_q     <= 1'b0;
            fill_we_q     <= 1'b0;
            fill_offset_q <= '0;
            fill_data_q   <= '0;
            crit_valid_q  <= 1'b0;
            crit_data_q   <= '0;
            fill_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            beat_q        <= beat_d;
            idle_q        <= idle_d;
            mem_req_q     <= mem_req_d;
            fill_we_q     <= fill_we_d;
            fill_offset_q <= fill_offset_d;
            fill_data_q   <= fill_data_d;
            crit_valid_q  <= crit_valid_d;
            crit_data_q   <= crit_data_d;
            fill_done_q   <= fill_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign miss_ready     = (state_q == ST_IDLE);
    assign MemReadRequest = mem_req_q;
    assign MemReadAddress = addr_q;
    assign fill_we        = fill_we_q;
    assign fill_offset    = fill_offset_q;
    assign fill_data      = fill_data_q;
    assign fill_addr      = {addr_q[31:2+OFFSET_W], {(2 + OFFSET_W){1'b0}}};
    assign fill_done      = fill_done_q;
    assign crit_valid     = crit_valid_q;
    assign crit_data      = crit_data_q;
    assign timeout_err    = timeout_err_q;

endmodule
